mem_stage_lsu: RTL

//  Parametrised successor to the MEM-stage data-memory wrapper. Adds RV32I sub-word loads/stores
//  (LB/LH/LW/LBU/LHU, SB/SH/SW) and byte-enabled writes, plus misalignment detection.

---
 rtl/mem_stage_lsu.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: owns the data memory, does RV32I sub-word
// loads/stores with byte enables, alignment checks and the MEM/WB payload.
//
// Ports:
//   clk, rst (async, active-high), stall (freeze everything)
//   in_*  : EX/MEM entry (valid, address/ALU result, store data, controls)
//   out_* : WB payload, READ_LATENCY accepted cycles after the entry
//           out_readdata    : extended load data, 0 when not a load
//           out_misalign    : the access failed its alignment check
module mem_stage_lsu #(
    parameter int    ADDR_W       = 13,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        in_valid,
    input  logic [31:0] in_aluresult,
    input  logic [31:0] in_writedata,
    input  logic        in_memwrite,
    input  logic        in_memread,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic        in_regwrite,
    input  logic [1:0]  in_resultsrc,
    input  logic [31:0] in_pcplus4,
    output logic        out_valid,
    output logic [31:0] out_aluresult,
    output logic [31:0] out_readdata,
    output logic [4:0]  out_rd,
    output logic        out_regwrite,
    output logic [1:0]  out_resultsrc,
    output logic [31:0] out_pcplus4,
    output logic        out_misalign
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef struct packed {
        logic        valid;
        logic [31:0] aluresult;
        logic [31:0] pcplus4;
        logic [4:0]  rd;
        logic        regwrite;
        logic [1:0]  resultsrc;
        logic        load;
        logic        misalign;
        logic [2:0]  funct3;
        logic [1:0]  off;
    } entry_t;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [1:0]        off;
    logic              bad_align;
    logic              mis_acc;
    logic              rd_en;
    logic              wr_en;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rdata_q;
    logic [31:0]       last_rdata;
    logic [15:0]       lane;
    entry_t            ent;
    entry_t            s1;
    entry_t            last;
    logic              unused_addr;

    // Upper address bits alias the array.
    assign unused_addr = ^in_aluresult[31:ADDR_W+2];
    assign idx = in_aluresult[ADDR_W+1:2];
    assign off = in_aluresult[1:0];

    always_comb begin
        bad_align = 1'b1;
        unique case (in_funct3)
            3'b000, 3'b100: bad_align = 1'b0;
            3'b001, 3'b101: bad_align = off[0];
            3'b010:         bad_align = (off != 2'b00);
            default:        bad_align = 1'b1;
        endcase
    end

    always_comb begin
        be    = 4'b1111;
        wdata = in_writedata;
        unique case (in_funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {4{in_writedata[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << off;
                wdata = {2{in_writedata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = in_writedata;
            end
        endcase
    end

    assign mis_acc = in_valid & (in_memread | in_memwrite) & bad_align;
    assign rd_en   = in_valid & ~stall & in_memread;
    assign wr_en   = in_valid & ~stall & in_memwrite & ~bad_align;

    // Read-first port: a same-cycle store+load sees the old word, while a
    // load on the following cycle sees the committed store.
    always_ff @(posedge clk) begin
        if (rd_en) rdata_q <= mem[idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_en && be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    always_comb begin
        ent           = '0;
        ent.valid     = in_valid;
        ent.aluresult = in_aluresult;
        ent.pcplus4   = in_pcplus4;
        ent.rd        = in_rd;
        ent.regwrite  = in_valid & in_regwrite & ~(mis_acc & in_memread);
        ent.resultsrc = in_resultsrc;
        ent.load      = in_valid & in_memread & ~bad_align;
        ent.misalign  = mis_acc;
        ent.funct3    = in_funct3;
        ent.off       = off;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         s1 <= '0;
        else if (!stall) s1 <= ent;
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign last       = s1;
        assign last_rdata = rdata_q;
    end else if (READ_LATENCY == 2) begin : g_lat2
        entry_t      s2;
        logic [31:0] rdata2;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)         s2 <= '0;
            else if (!stall) s2 <= s1;
        end
        // Data path needs no reset; out_readdata is gated by s2.load.
        always_ff @(posedge clk) begin
            if (!stall) rdata2 <= rdata_q;
        end
        assign last       = s2;
        assign last_rdata = rdata2;
    end else begin : g_bad_latency
        $error("mem_stage_lsu: READ_LATENCY must be 1 or 2");
    end

    assign lane = 16'(last_rdata >> {last.off, 3'b000});

    always_comb begin
        out_readdata = 32'h0;
        if (last.load) begin
            unique case (last.funct3)
                3'b000:  out_readdata = {{24{lane[7]}}, lane[7:0]};
                3'b001:  out_readdata = {{16{lane[15]}}, lane};
                3'b100:  out_readdata = {24'h0, lane[7:0]};
                3'b101:  out_readdata = {16'h0, lane};
                default: out_readdata = last_rdata;
            endcase
        end
    end

    assign out_valid     = last.valid;
    assign out_aluresult = last.aluresult;
    assign out_rd        = last.rd;
    assign out_regwrite  = last.regwrite;
    assign out_resultsrc = last.resultsrc;
    assign out_pcplus4   = last.pcplus4;
    assign out_misalign  = last.misalign;
endmodule
